data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's data-memory port.
- Accepts load and store requests over a valid/ready handshake and serves them from an internal little-endian byte array.
- Supports word and byte (ByteOp) accesses.
- Returns load data after a configurable latency, so the pipeline can be exercised against a multi-cycle memory instead of a zero-latency array.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 for byte-lane logic.
- ADDR_WIDTH, 17, byte-address bits actually decoded; memory holds 2^ADDR_WIDTH bytes.
- LATENCY, 2, cycles from load acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  DATA_WIDTH  byte address; only bits [ADDR_WIDTH-1:0] are used.
- req_wdata  in  DATA_WIDTH  store data; byte store uses bits [7:0].
- resp_valid  out  1  one-cycle pulse: load data or store acknowledge.
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  misaligned word access; valid only with resp_valid.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Memory contents are not cleared.
  - Reset mid-operation abandons the pending request: no response is issued.
  - A store already committed stays written.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - Request fields are sampled only at acceptance; the initiator may change them afterwards.
- FSM states: IDLE, WAIT, RESP.
- IDLE, store accepted:
  - The memory write commits on the acceptance edge.
  - Next state is RESP; resp_valid=1 and resp_rdata=0 on the following cycle.
  - Store response latency is 1.
- IDLE, load accepted:
  - Address and byte flag are latched and the counter loads LATENCY-1.
  - If LATENCY=1, go directly to RESP; otherwise go to WAIT.
- WAIT: counter decrements each cycle; go to RESP when counter==1.
- Load timing: resp_valid is asserted exactly LATENCY cycles after the acceptance edge.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during RESP, so back-to-back requests are spaced by at least 2 cycles.
- Outputs are registered. resp_rdata and resp_err hold their last values while resp_valid=0; benches only check them when resp_valid=1.
- Word access:
  - Bytes addr, addr+1, addr+2, addr+3 map to bits [7:0], [15:8], [23:16], [31:24] (little-endian).
  - If addr[1:0] != 0: no memory write, resp_err=1, resp_rdata=0. Timing is unchanged (store latency 1, load latency LATENCY).
- Byte access:
  - Any alignment is legal.
  - Store writes req_wdata[7:0] only; the other bytes are untouched.
  - Load returns the byte zero-extended to 32 bits.
- Address wrap: upper address bits are ignored, so 0x0002_0004 aliases 0x0_0004 at default ADDR_WIDTH.
- req_valid while req_ready=0 is ignored (not queued). The initiator must hold req_valid until accepted.
- Optional: contents may be preloaded by $readmemh from a parameterised file at elaboration; this must not affect reset behaviour.

Test Plan:
- Reset then word store 0xDEADBEEF @0x100, then word load @0x100 (LATENCY=2) -> store ack 1 cycle after accept; load resp_valid exactly 2 cycles after accept with rdata 0xDEADBEEF, err=0.
- Byte store 0xAA @0x101 over word 0x11223344 @0x100, then word load @0x100 -> 0x1122AA44; byte load @0x101 -> 0x000000AA.
- Word load @0x102 and word store @0x106 -> resp_err=1, rdata=0; follow-up word load @0x104 shows the prior contents unchanged.
- Hold req_valid=1 continuously with 3 loads -> req_ready low in WAIT/RESP; each accepted exactly once, with 3 resp_valid pulses in order and no duplicates.
- Drive rst=0 asynchronously mid-WAIT of a load -> resp_valid never pulses for it; req_ready=1 immediately; memory keeps earlier stores.
- LATENCY=1 build: word load @0x0 of 0x00000007 -> resp_valid on the cycle after acceptance; alias address 0x0002_0000 returns the same value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves CPU load/store requests from an internal little-endian byte
// array over a valid/ready handshake. Loads respond after LATENCY cycles, stores after one.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e r_state, w_state_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic r_byte, w_byte_d;
  logic r_resp_valid, w_resp_valid_d;
  logic [DATA_WIDTH-1:0] r_resp_rdata, w_resp_rdata_d;
  logic r_resp_err, w_resp_err_d;

  // Byte storage; deliberately not reset so committed stores survive rst.
  logic [7:0] r_mem [2**ADDR_WIDTH];

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_req_misal;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_byte;
  logic                  w_load_err;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_unused_addr;

  // Upper address bits are ignored so that high addresses alias into the array.
  assign w_unused_addr = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign req_ready   = (r_state == StIdle);
  assign w_accept    = req_valid & req_ready;
  assign w_req_addr  = req_addr[ADDR_WIDTH-1:0];
  assign w_req_misal = ~req_byte & (req_addr[1:0] != 2'b00);
  assign w_wr_en     = w_accept & req_we & ~w_req_misal;

  // In IDLE the read path looks at the live request (needed when LATENCY=1); otherwise at the
  // latched load address.
  assign w_rd_addr  = (r_state == StIdle) ? w_req_addr : r_addr;
  assign w_rd_byte  = (r_state == StIdle) ? req_byte : r_byte;
  assign w_load_err = ~w_rd_byte & (w_rd_addr[1:0] != 2'b00);

  // Assemble load data: zero-extended byte or little-endian word.
  always_comb begin
    w_load_data = '0;
    if (w_rd_byte) begin
      w_load_data[7:0] = r_mem[w_rd_addr];
    end else begin
      w_load_data = {r_mem[w_rd_addr + ADDR_WIDTH'(3)], r_mem[w_rd_addr + ADDR_WIDTH'(2)],
                     r_mem[w_rd_addr + ADDR_WIDTH'(1)], r_mem[w_rd_addr]};
    end
  end

  // Store commits on the acceptance edge; misaligned word stores never write.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_req_addr] <= req_wdata[7:0];
      if (!req_byte) begin
        r_mem[w_req_addr + ADDR_WIDTH'(1)] <= req_wdata[15:8];
        r_mem[w_req_addr + ADDR_WIDTH'(2)] <= req_wdata[23:16];
        r_mem[w_req_addr + ADDR_WIDTH'(3)] <= req_wdata[31:24];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_addr_d       = r_addr;
    w_byte_d       = r_byte;
    w_resp_valid_d = 1'b0;
    w_resp_rdata_d = r_resp_rdata;
    w_resp_err_d   = r_resp_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_addr_d = w_req_addr;
          w_byte_d = req_byte;
          if (req_we) begin
            w_state_d      = StResp;
            w_resp_valid_d = 1'b1;
            w_resp_rdata_d = '0;
            w_resp_err_d   = w_req_misal;
          end else begin
            w_cnt_d = 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              w_state_d      = StResp;
              w_resp_valid_d = 1'b1;
              w_resp_rdata_d = w_load_err ? '0 : w_load_data;
              w_resp_err_d   = w_load_err;
            end else begin
              w_state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_d      = StResp;
          w_resp_valid_d = 1'b1;
          w_resp_rdata_d = w_load_err ? '0 : w_load_data;
          w_resp_err_d   = w_load_err;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Control and response registers; async reset drops any pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_byte       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_addr       <= w_addr_d;
      r_byte       <= w_byte_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_err   <= w_resp_err_d;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_valid, l1_ready, l1_we, l1_byte;
  logic [31:0] l1_addr, l1_wdata;
  logic        l1_resp_valid, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1)) dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (l1_valid),
    .req_ready (l1_ready),
    .req_we    (l1_we),
    .req_byte  (l1_byte),
    .req_addr  (l1_addr),
    .req_wdata (l1_wdata),
    .resp_valid(l1_resp_valid),
    .resp_rdata(l1_resp_rdata),
    .resp_err  (l1_resp_err)
  );

  // Issue one request to the LATENCY=2 instance; latency counts edges after acceptance.
  task automatic do_req(input logic we, input logic b, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = b; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Scramble fields: only the acceptance-edge values may matter.
    req_valid = 1'b0; req_we = ~we; req_byte = ~b; req_addr = 32'h0001_FFFC; req_wdata = '0;
    lat = -1; rd = 32'hX; er = 1'bX;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic do_req1(input logic we, input logic b, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic er);
    int n;
    @(negedge clk);
    l1_valid = 1'b1; l1_we = we; l1_byte = b; l1_addr = a; l1_wdata = d;
    n = 0;
    while (!l1_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    l1_valid = 1'b0; l1_addr = 32'h0001_FFF0; l1_wdata = '0;
    lat = -1; rd = 32'hX; er = 1'bX;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (l1_resp_valid) begin
        lat = i; rd = l1_resp_rdata; er = l1_resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", resp_err); end
    n_checks++;
    if (l1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_l1_ready: got %b want 1", l1_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL store_latency: got %0d want 1", lat); end
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL store_ack: got rdata=%h err=%b want 0/0", rd, er);
    end
    do_req(1'b0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL load_word: got %h err=%b want deadbeef/0", rd, er);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 1'b0, 32'h100, 32'h11223344, lat, rd, er);
    do_req(1'b1, 1'b1, 32'h101, 32'h123456AA, lat, rd, er);
    n_checks++;
    if (lat !== 1 || er !== 1'b0) begin
      n_fail++; $display("FAIL byte_store_ack: got lat=%0d err=%b want 1/0", lat, er);
    end
    do_req(1'b0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_merge: got %h want 1122aa44", rd); end
    do_req(1'b0, 1'b1, 32'h101, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h000000AA || lat !== 2) begin
      n_fail++; $display("FAIL byte_load_101: got %h lat=%0d want 000000aa/2", rd, lat);
    end
    do_req(1'b0, 1'b1, 32'h103, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h00000011 || er !== 1'b0) begin
      n_fail++; $display("FAIL byte_load_103: got %h err=%b want 00000011/0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 1'b0, 32'h104, 32'h55667788, lat, rd, er);
    do_req(1'b0, 1'b0, 32'h102, 32'h0, lat, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      n_fail++; $display("FAIL misal_load: got err=%b rdata=%h lat=%0d want 1/0/2", er, rd, lat);
    end
    do_req(1'b1, 1'b0, 32'h106, 32'hCAFEF00D, lat, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL misal_store: got err=%b rdata=%h lat=%0d want 1/0/1", er, rd, lat);
    end
    do_req(1'b0, 1'b0, 32'h104, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h55667788 || er !== 1'b0) begin
      n_fail++; $display("FAIL misal_no_write: got %h err=%b want 55667788/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic        bytes [3];
    logic [31:0] exp   [3];
    logic [31:0] got   [4];
    int acc_cyc [3];
    int acc, nresp;
    logic take;
    addrs[0] = 32'h100; bytes[0] = 1'b0; exp[0] = 32'h1122AA44;
    addrs[1] = 32'h104; bytes[1] = 1'b0; exp[1] = 32'h55667788;
    addrs[2] = 32'h101; bytes[2] = 1'b1; exp[2] = 32'h000000AA;
    acc = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = bytes[0]; req_addr = addrs[0];
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (resp_valid) begin
        if (nresp < 4) got[nresp] = resp_rdata;
        nresp++;
      end
      take = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (take) begin
        if (acc < 3) acc_cyc[acc] = cyc;
        acc++;
        if (acc < 3) begin
          req_byte = bytes[acc]; req_addr = addrs[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    n_checks++;
    if (nresp !== 3) begin n_fail++; $display("FAIL b2b_responses: got %0d want 3", nresp); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (nresp > i && got[i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], exp[i]);
      end else if (nresp <= i) begin
        n_fail++; $display("FAIL b2b_data%0d: got none want %h", i, exp[i]);
      end
    end
    if (acc >= 3) begin
      n_checks++;
      if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d,%0d want 3,3", acc_cyc[1] - acc_cyc[0],
                 acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic er;
    int pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_pulse: got %0d want 0", pulses); end
    do_req(1'b0, 1'b0, 32'h104, 32'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h55667788 || lat !== 2) begin
      n_fail++; $display("FAIL rst_mid_mem: got %h lat=%0d want 55667788/2", rd, lat);
    end
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; logic er;
    do_req1(1'b1, 1'b0, 32'h0, 32'h00000007, lat, rd, er);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL l1_store_latency: got %0d want 1", lat); end
    do_req1(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er);
    n_checks++;
    if (lat !== 1 || rd !== 32'h7 || er !== 1'b0) begin
      n_fail++; $display("FAIL l1_load: got lat=%0d rdata=%h err=%b want 1/7/0", lat, rd, er);
    end
    do_req1(1'b0, 1'b0, 32'h0002_0000, 32'h0, lat, rd, er);
    n_checks++;
    if (lat !== 1 || rd !== 32'h7) begin
      n_fail++; $display("FAIL l1_alias: got lat=%0d rdata=%h want 1/7", lat, rd);
    end
    do_req1(1'b0, 1'b0, 32'h2, 32'h0, lat, rd, er);
    n_checks++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL l1_misal: got lat=%0d rdata=%h err=%b want 1/0/1", lat, rd, er);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    l1_valid = 1'b0; l1_we = 1'b0; l1_byte = 1'b0; l1_addr = '0; l1_wdata = '0;
    test_reset();
    test_word_rw();
    test_byte();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wait();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
